// File: rtl/rst_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : rst_key_ctrl
// Brief   : Reset-button stretcher plus per-key debouncer with press/release
//           pulses and wrapping press counters.
// Revision: 1.0 - initial release
// ============================================================================
module rst_key_ctrl #(
    parameter int NUM_KEYS        = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RST_STRETCH     = 15,
    parameter int CNT_WIDTH       = 4,
    parameter int KEY_ACTIVE_LOW  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rst_in_n,
    input  logic [NUM_KEYS-1:0]           key_raw,
    output logic                          sys_rst,
    output logic [NUM_KEYS-1:0]           key_state,
    output logic [NUM_KEYS-1:0]           key_press,
    output logic [NUM_KEYS-1:0]           key_release,
    output logic [NUM_KEYS*CNT_WIDTH-1:0] press_cnt
);

    localparam int                c_DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int                c_ST_W     = $clog2(RST_STRETCH + 1);
    localparam logic [c_DB_W-1:0] c_DB_LAST  = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_DB_W-1:0] c_DB_ONE   = c_DB_W'(1);
    localparam logic [c_ST_W-1:0] c_ST_LOAD  = c_ST_W'(RST_STRETCH);
    localparam logic [c_ST_W-1:0] c_ST_ONE   = c_ST_W'(1);
    localparam logic              c_KEY_IDLE = (KEY_ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        S_RELEASED     = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_PRESSED      = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } key_fsm_t;

    logic [1:0]          r_rstn_sync;
    logic [NUM_KEYS-1:0] r_key_s0;
    logic [NUM_KEYS-1:0] r_key_s1;
    logic [c_ST_W-1:0]   r_stretch;
    logic                r_sys_rst;
    logic                w_hold;
    logic [NUM_KEYS-1:0] w_key;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rstn_sync <= 2'b11;
            r_key_s0    <= {NUM_KEYS{c_KEY_IDLE}};
            r_key_s1    <= {NUM_KEYS{c_KEY_IDLE}};
        end else begin
            r_rstn_sync <= {r_rstn_sync[0], rst_in_n};
            r_key_s0    <= key_raw;
            r_key_s1    <= r_key_s0;
        end
    end

    // Key logic is cleared one cycle ahead of sys_rst, so it is always idle
    // whenever sys_rst reads high and starts debouncing the cycle it falls.
    assign w_hold = (r_stretch != '0);
    assign w_key  = r_key_s1 ^ {NUM_KEYS{c_KEY_IDLE}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stretch <= c_ST_LOAD;
            r_sys_rst <= 1'b1;
        end else begin
            if (!r_rstn_sync[1]) begin
                r_stretch <= c_ST_LOAD;
            end else if (w_hold) begin
                r_stretch <= r_stretch - c_ST_ONE;
            end
            r_sys_rst <= w_hold;
        end
    end

    assign sys_rst = r_sys_rst;

    generate
        for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
            key_fsm_t             r_state;
            key_fsm_t             w_state_next;
            logic [c_DB_W-1:0]    r_db_cnt;
            logic [c_DB_W-1:0]    w_db_cnt_next;
            logic [CNT_WIDTH-1:0] r_press_cnt;
            logic                 r_press;
            logic                 r_release;
            logic                 w_press_next;
            logic                 w_release_next;

            always_comb begin
                w_state_next   = r_state;
                w_db_cnt_next  = r_db_cnt;
                w_press_next   = 1'b0;
                w_release_next = 1'b0;
                if (w_hold) begin
                    w_state_next  = S_RELEASED;
                    w_db_cnt_next = '0;
                end else begin
                    case (r_state)
                        S_RELEASED: begin
                            if (w_key[i]) begin
                                w_state_next  = S_PRESS_WAIT;
                                w_db_cnt_next = '0;
                            end
                        end
                        S_PRESS_WAIT: begin
                            if (!w_key[i]) begin
                                w_state_next  = S_RELEASED;
                                w_db_cnt_next = '0;
                            end else if (r_db_cnt == c_DB_LAST) begin
                                w_state_next  = S_PRESSED;
                                w_db_cnt_next = '0;
                                w_press_next  = 1'b1;
                            end else begin
                                w_db_cnt_next = r_db_cnt + c_DB_ONE;
                            end
                        end
                        S_PRESSED: begin
                            if (!w_key[i]) begin
                                w_state_next  = S_RELEASE_WAIT;
                                w_db_cnt_next = '0;
                            end
                        end
                        S_RELEASE_WAIT: begin
                            if (w_key[i]) begin
                                w_state_next  = S_PRESSED;
                                w_db_cnt_next = '0;
                            end else if (r_db_cnt == c_DB_LAST) begin
                                w_state_next   = S_RELEASED;
                                w_db_cnt_next  = '0;
                                w_release_next = 1'b1;
                            end else begin
                                w_db_cnt_next = r_db_cnt + c_DB_ONE;
                            end
                        end
                        default: begin
                            w_state_next  = S_RELEASED;
                            w_db_cnt_next = '0;
                        end
                    endcase
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_state     <= S_RELEASED;
                    r_db_cnt    <= '0;
                    r_press     <= 1'b0;
                    r_release   <= 1'b0;
                    r_press_cnt <= '0;
                end else begin
                    r_state   <= w_state_next;
                    r_db_cnt  <= w_db_cnt_next;
                    r_press   <= w_press_next;
                    r_release <= w_release_next;
                    if (w_hold) begin
                        r_press_cnt <= '0;
                    end else if (w_press_next) begin
                        r_press_cnt <= r_press_cnt + 1'b1;
                    end
                end
            end

            assign key_state[i]   = (r_state == S_PRESSED) || (r_state == S_RELEASE_WAIT);
            assign key_press[i]   = r_press;
            assign key_release[i] = r_release;
            assign press_cnt[i*CNT_WIDTH +: CNT_WIDTH] = r_press_cnt;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_rst_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_rst_key_ctrl
// Brief   : Self-checking bench for rst_key_ctrl (table, directed, random).
// Revision: 1.0 - initial release
// ============================================================================
module tb_rst_key_ctrl;

    localparam int D  = 4;
    localparam int RS = 3;
    localparam int NK = 2;
    localparam int CW = 2;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       rst_in_n = 1'b1;
    logic [1:0] key_raw  = 2'b11;
    logic       sys_rst;
    logic [1:0] key_state;
    logic [1:0] key_press;
    logic [1:0] key_release;
    logic [3:0] press_cnt;

    int n_total = 0;
    int n_bad   = 0;

    rst_key_ctrl #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (D),
        .RST_STRETCH     (RS),
        .CNT_WIDTH       (CW),
        .KEY_ACTIVE_LOW  (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rst_in_n    (rst_in_n),
        .key_raw     (key_raw),
        .sys_rst     (sys_rst),
        .key_state   (key_state),
        .key_press   (key_press),
        .key_release (key_release),
        .press_cnt   (press_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: histories of raw samples plus run lengths per key.
    logic       m_rq[$];
    logic [1:0] m_kq[$];
    logic       m_st[NK];
    int         m_run[NK];
    int         m_cnt[NK];
    logic       m_sys;
    logic [1:0] m_kstate, m_press, m_rel;
    logic [3:0] m_pcnt;

    typedef struct {
        logic       rstn;
        logic [1:0] keys;
        logic       sys;
        logic [1:0] kst;
        logic [1:0] kp;
        logic [1:0] kr;
        logic [3:0] cnt;
    } vec_t;
    vec_t tbl[20];

    int         np, nr, ng, fall, pr, seen;
    int         got[5];
    int         exp_w[5];
    logic [1:0] rk;
    logic       rr;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rq.delete();
        repeat (RS + 2) m_rq.push_back(1'b0);
        m_rq.push_back(1'b1);
        m_rq.push_back(1'b1);
        m_kq.delete();
        m_kq.push_back(2'b11);
        m_kq.push_back(2'b11);
        for (int k = 0; k < NK; k++) begin
            m_st[k]  = 1'b0;
            m_run[k] = 0;
            m_cnt[k] = 0;
        end
        m_sys = 1'b1; m_kstate = '0; m_press = '0; m_rel = '0; m_pcnt = '0;
    endtask

    // sys_rst is high while any raw rst_in_n sample aged 3..RS+2 edges was low;
    // the key logic is idle in exactly those cycles. A level is accepted after
    // the detecting cycle plus D further cycles that all differ from the state.
    task automatic model_edge(input logic rstn, input logic [1:0] keys);
        logic       hold;
        logic [1:0] v;
        m_rq.push_back(rstn);
        while (m_rq.size() > RS + 3) m_rq.delete(0);
        hold = 1'b0;
        for (int a = 3; a <= RS + 2; a++)
            if (m_rq[m_rq.size() - 1 - a] == 1'b0) hold = 1'b1;
        m_kq.push_back(keys);
        while (m_kq.size() > 3) m_kq.delete(0);
        v = ~m_kq[0];
        m_press = '0;
        m_rel   = '0;
        for (int k = 0; k < NK; k++) begin
            if (hold) begin
                m_st[k] = 1'b0; m_run[k] = 0; m_cnt[k] = 0;
            end else if (v[k] != m_st[k]) begin
                m_run[k]++;
                if (m_run[k] == D + 1) begin
                    m_st[k]  = v[k];
                    m_run[k] = 0;
                    if (v[k]) begin
                        m_press[k] = 1'b1;
                        m_cnt[k]   = (m_cnt[k] + 1) % (1 << CW);
                    end else begin
                        m_rel[k] = 1'b1;
                    end
                end
            end else begin
                m_run[k] = 0;
            end
        end
        m_sys    = hold;
        m_kstate = {m_st[1], m_st[0]};
        m_pcnt   = {2'(m_cnt[1]), 2'(m_cnt[0])};
    endtask

    task automatic step(input logic rstn, input logic [1:0] keys);
        rst_in_n = rstn;
        key_raw  = keys;
        @(posedge clk);
        model_edge(rstn, keys);
        #1;
        check("m_sys_rst",   8'(sys_rst),     8'(m_sys));
        check("m_key_state", 8'(key_state),   8'(m_kstate));
        check("m_key_press", 8'(key_press),   8'(m_press));
        check("m_key_rel",   8'(key_release), 8'(m_rel));
        check("m_press_cnt", 8'(press_cnt),   8'(m_pcnt));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Clean power-up: press key 0 at edge 5, release at edge 13.
        for (int i = 0; i < 20; i++) begin
            int t;
            t = i + 1;
            tbl[i].rstn = 1'b1;
            tbl[i].keys = (t >= 5 && t <= 12) ? 2'b10 : 2'b11;
            tbl[i].sys  = (t <= 3);
            tbl[i].kst  = (t >= 11 && t <= 18) ? 2'b01 : 2'b00;
            tbl[i].kp   = (t == 11) ? 2'b01 : 2'b00;
            tbl[i].kr   = (t == 19) ? 2'b01 : 2'b00;
            tbl[i].cnt  = (t >= 11) ? 4'b0001 : 4'b0000;
        end
        exp_w = '{1, 2, 3, 0, 1};

        #1 rst = 1'b1;
        #1;
        check("rst_sys_rst",   8'(sys_rst),     8'd1);
        check("rst_key_state", 8'(key_state),   8'd0);
        check("rst_key_press", 8'(key_press),   8'd0);
        check("rst_key_rel",   8'(key_release), 8'd0);
        check("rst_press_cnt", 8'(press_cnt),   8'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        model_reset();

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].rstn, tbl[i].keys);
            check($sformatf("tbl%0d_sys", i), 8'(sys_rst),     8'(tbl[i].sys));
            check($sformatf("tbl%0d_kst", i), 8'(key_state),   8'(tbl[i].kst));
            check($sformatf("tbl%0d_kp", i),  8'(key_press),   8'(tbl[i].kp));
            check($sformatf("tbl%0d_kr", i),  8'(key_release), 8'(tbl[i].kr));
            check($sformatf("tbl%0d_cnt", i), 8'(press_cnt),   8'(tbl[i].cnt));
        end

        // One-cycle reset-button pulse: sys_rst falls 5 edges after the rise.
        step(1'b0, 2'b11);
        step(1'b1, 2'b11);
        fall = -1; seen = 0;
        for (int n = 1; n <= 20; n++) begin
            step(1'b1, 2'b11);
            if (sys_rst) seen = 1;
            if (seen != 0 && !sys_rst && fall < 0) fall = n;
        end
        check("stretch_fall", 8'(fall), 8'd5);

        // Bounce rejection on key 0.
        np = 0;
        repeat (3) step(1'b1, 2'b11);
        repeat (3) begin step(1'b1, 2'b10); np += int'(key_press[0]); end
        step(1'b1, 2'b11); np += int'(key_press[0]);
        repeat (3) begin step(1'b1, 2'b10); np += int'(key_press[0]); end
        repeat (8) begin step(1'b1, 2'b11); np += int'(key_press[0]); end
        check("bounce_press", 8'(np),           8'd0);
        check("bounce_state", 8'(key_state[0]), 8'd0);
        check("bounce_cnt",   8'(press_cnt[1:0]), 8'd0);

        // Counter wrap on key 1.
        ng = 0; nr = 0;
        for (int j = 0; j < 5; j++) got[j] = -1;
        for (int r = 0; r < 5; r++) begin
            for (int s = 0; s < 20; s++) begin
                step(1'b1, (s < 10) ? 2'b01 : 2'b11);
                if (key_press[1]) begin
                    if (ng < 5) got[ng] = int'(press_cnt[3:2]);
                    ng++;
                end
                nr += int'(key_release[1]);
            end
        end
        check("wrap_presses",  8'(ng), 8'd5);
        check("wrap_releases", 8'(nr), 8'd5);
        for (int j = 0; j < 5; j++) check($sformatf("wrap_cnt%0d", j), 8'(got[j]), 8'(exp_w[j]));

        // Both keys together, then a reset-button pulse while both are held.
        np = 0;
        for (int n = 0; n < 12; n++) begin
            step(1'b1, 2'b00);
            if (key_press != 2'b00) begin
                np++;
                check("simul_press", 8'(key_press), 8'b11);
            end
        end
        check("simul_press_count", 8'(np), 8'd1);
        step(1'b0, 2'b00);
        fall = -1; pr = -1; seen = 0;
        for (int n = 1; n <= 20; n++) begin
            step(1'b1, 2'b00);
            if (sys_rst) begin
                seen = 1;
                check("simul_state_in_rst", 8'(key_state), 8'd0);
            end
            if (seen != 0 && !sys_rst && fall < 0) fall = n;
            if (fall >= 0 && key_press != 2'b00 && pr < 0) begin
                pr = n;
                check("simul_repress", 8'(key_press), 8'b11);
            end
        end
        check("simul_repress_delay", 8'(pr - fall), 8'd4);
        repeat (10) step(1'b1, 2'b11);

        // Asynchronous reset in the middle of a debounce.
        repeat (4) step(1'b1, 2'b10);
        #2 rst = 1'b1;
        #1;
        check("midrst_sys",   8'(sys_rst),   8'd1);
        check("midrst_state", 8'(key_state), 8'd0);
        check("midrst_press", 8'(key_press), 8'd0);
        check("midrst_cnt",   8'(press_cnt), 8'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("midrst_press_held", 8'(key_press), 8'd0);
        #2 rst = 1'b0;
        model_reset();
        np = 0;
        repeat (12) begin step(1'b1, 2'b10); np += int'(key_press[0]); end
        check("midrst_fresh_press", 8'(np), 8'd1);
        repeat (10) step(1'b1, 2'b11);

        // Random traffic against the model.
        rk = 2'b11;
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < NK; k++)
                if ($urandom_range(0, 6) == 0) rk[k] = ~rk[k];
            rr = ($urandom_range(0, 79) != 0);
            step(rr, rk);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rst_key_ctrl.md
RST_KEY_CTRL -- requirements
Module: rst_key_ctrl

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 2: number of independent key channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500000: stable cycles before accepting a key edge (10 ms at 50 MHz); legal range 2 or more.
REQ-003 SHALL have parameter RST_STRETCH, default 15: cycles sys_rst is held after the reset sources release; legal range 1 or more.
REQ-004 SHALL have parameter CNT_WIDTH, default 4: width of each per-key press counter.
REQ-005 SHALL have parameter KEY_ACTIVE_LOW, default 1: 1 means a raw key level of 0 is "pressed".
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port rst_in_n, input, 1 bit: external reset button, active-low, asynchronous to clk.
REQ-009 SHALL have port key_raw, input, NUM_KEYS bits: raw key pins, asynchronous to clk.
REQ-010 SHALL have port sys_rst, output, 1 bit: stretched system reset, active-high.
REQ-011 SHALL have port key_state, output, NUM_KEYS bits: debounced level per key, 1 = pressed.
REQ-012 SHALL have port key_press, output, NUM_KEYS bits: one-cycle pulse per accepted press.
REQ-013 SHALL have port key_release, output, NUM_KEYS bits: one-cycle pulse per accepted release.
REQ-014 SHALL have port press_cnt, output, NUM_KEYS*CNT_WIDTH bits: per-key press count; key i occupies bits [i*CNT_WIDTH +: CNT_WIDTH].

Function
REQ-015 SHALL pass rst_in_n and every key_raw bit through a 2-flop synchronizer before use; the synchronizers are reset to the released level.
REQ-016 SHALL normalise each synchronized key to active-high according to KEY_ACTIVE_LOW.
REQ-017 SHALL hold a stretch counter:
- load RST_STRETCH while the synchronized rst_in_n is 0;
- otherwise decrement it when nonzero, holding at 0.
REQ-018 SHALL drive sys_rst = 1 exactly when the stretch counter is nonzero, registered; after rst_in_n rises, sys_rst falls RST_STRETCH+2 cycles later (2 of those cycles are synchronizer latency).
REQ-019 SHALL run per key a 4-state FSM: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-020 SHALL move RELEASED->PRESS_WAIT when the normalised key is 1, and PRESSED->RELEASE_WAIT when it is 0; the debounce counter clears on entry.
REQ-021 SHALL, in either WAIT state, increment the debounce counter each cycle the input matches the target level.
REQ-022 SHALL, in either WAIT state, return to the prior stable state on any mismatching cycle (bounce), clearing the counter and producing no pulse.
REQ-023 SHALL take the WAIT->target transition in the cycle the counter equals DEBOUNCE_CYCLES-1 with a matching input, so an accepted edge needs exactly DEBOUNCE_CYCLES consecutive matching cycles.
REQ-024 SHALL pulse key_press (PRESS_WAIT->PRESSED) or key_release (RELEASE_WAIT->RELEASED) for exactly one cycle, registered and coincident with the key_state change.
REQ-025 SHALL increment press_cnt[i] on each key_press[i], wrapping modulo 2^CNT_WIDTH.
REQ-026 SHALL keep channels fully independent; simultaneous events on several keys SHALL all be reported in the same cycle.
REQ-027 SHALL, while sys_rst = 1, synchronously force every key FSM to RELEASED, clear all debounce counters and press_cnt, and hold key_press and key_release at 0; a key held through the end of reset is accepted as a fresh press after DEBOUNCE_CYCLES.
REQ-028 SHALL size the debounce counter to clog2(DEBOUNCE_CYCLES) bits; it never wraps.

Reset
REQ-029 SHALL, on rst = 1, asynchronously set:
- stretch counter = RST_STRETCH and sys_rst = 1;
- synchronizers to the released level;
- FSMs to RELEASED, all counters to 0;
- key_state, key_press, key_release and press_cnt to 0.
REQ-030 SHALL, on rst deassertion with rst_in_n = 1, drop sys_rst after RST_STRETCH cycles.
REQ-031 SHALL, on rst or rst_in_n asserted mid-debounce, abandon the debounce with no pulse emitted.

Verification (DEBOUNCE_CYCLES=4, RST_STRETCH=3, NUM_KEYS=2, CNT_WIDTH=2, KEY_ACTIVE_LOW=1)
REQ-032 SHALL cover reset stretch: release rst with rst_in_n=1 -> sys_rst stays 1 for 3 cycles, then 0; pulse rst_in_n low 1 cycle -> sys_rst high again, falling 5 cycles after rst_in_n rises.
REQ-033 SHALL cover a clean press: key_raw[0]=0 held -> key_press[0] pulses once, 6 cycles after the change (2 sync + 4 debounce), then key_state[0]=1 and press_cnt[0]=1.
REQ-034 SHALL cover bounce rejection: key_raw[0] low 3 cycles, high 1, low 3, high -> no key_press, key_state[0] stays 0, press_cnt[0]=0.
REQ-035 SHALL cover counter wrap: 5 clean press/release cycles on key 1 -> press_cnt[1] reads 1,2,3,0,1 and 5 key_release pulses.
REQ-036 SHALL cover simultaneous keys: both keys pressed in the same cycle -> key_press=2'b11 in one cycle; then rst_in_n pulsed while both are held -> key_state=0 during sys_rst, and both presses re-accepted 4 cycles after sys_rst falls.
